// File: rtl/pc_interface_reg_bank.sv
// Double-buffered PC-interface register bank. PC writes go to a shadow set, and a commit copies
// the whole shadow set into the active set, either at once or on the next generator sync.
module pc_interface_reg_bank #(
  parameter int unsigned           DATA_WIDTH  = 16,
  parameter int unsigned           ADDR_WIDTH  = 3,
  parameter int unsigned           NUM_REGS    = 8,
  parameter bit                    SYNC_COMMIT = 1'b1,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           i_clk,
  input  logic                           i_arst_n,
  input  logic                           i_wr_valid,
  output logic                           o_wr_ready,
  input  logic [ADDR_WIDTH-1:0]          i_wr_addr,
  input  logic [DATA_WIDTH-1:0]          i_wr_data,
  input  logic [DATA_WIDTH/8-1:0]        i_wr_be,
  input  logic                           i_commit,
  input  logic                           i_abort,
  input  logic                           i_sync,
  input  logic                           i_rd,
  input  logic [ADDR_WIDTH-1:0]          i_rd_addr,
  input  logic                           i_rd_sel,
  output logic [DATA_WIDTH-1:0]          o_rd_data,
  output logic                           o_rd_valid,
  output logic                           o_err,
  output logic                           o_commit_pending,
  output logic                           o_commit_done,
  output logic [DATA_WIDTH*NUM_REGS-1:0] o_data
);

  localparam int unsigned           NumBytes = DATA_WIDTH / 8;
  // One extra bit so NUM_REGS == 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0]   NumRegsW = (ADDR_WIDTH + 1)'(NUM_REGS);

  typedef enum logic [1:0] {StIdle, StWaitSync, StCopy} state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   shadow_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   shadow_d [NUM_REGS];
  logic [DATA_WIDTH-1:0]   active_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   rd_data_q, rd_word;
  logic                    rd_valid_q, err_q, done_q;
  logic                    wr_fire, wr_in_range, rd_in_range;

  assign o_wr_ready       = (state_q == StIdle);
  assign o_commit_pending = (state_q == StWaitSync) || (state_q == StCopy);
  assign wr_fire          = i_wr_valid && o_wr_ready;
  assign wr_in_range      = {1'b0, i_wr_addr} < NumRegsW;
  assign rd_in_range      = {1'b0, i_rd_addr} < NumRegsW;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (i_commit) state_d = SYNC_COMMIT ? StWaitSync : StCopy;
      end
      StWaitSync: begin
        if (i_abort)     state_d = StIdle;
        else if (i_sync) state_d = StCopy;
      end
      StCopy:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    shadow_d = shadow_q;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (wr_fire && (i_wr_addr == ADDR_WIDTH'(i))) begin
        for (int unsigned b = 0; b < NumBytes; b++) begin
          if (i_wr_be[b]) shadow_d[i][8*b +: 8] = i_wr_data[8*b +: 8];
        end
      end
    end
  end

  // Out-of-range addresses match no register, so they read back as zero.
  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (i_rd_addr == ADDR_WIDTH'(i)) rd_word = i_rd_sel ? active_q[i] : shadow_q[i];
    end
  end

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q    <= StIdle;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= RESET_VALUE;
        active_q[i] <= RESET_VALUE;
      end
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      if (state_q == StCopy) active_q <= shadow_q;
      rd_valid_q <= i_rd;
      if (i_rd) rd_data_q <= rd_word;
      err_q      <= (wr_fire && !wr_in_range) || (i_rd && !rd_in_range);
      done_q     <= (state_q == StCopy);
    end
  end

  always_comb begin
    o_data = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      o_data[i*DATA_WIDTH +: DATA_WIDTH] = active_q[i];
    end
  end

  assign o_rd_data     = rd_data_q;
  assign o_rd_valid    = rd_valid_q;
  assign o_err         = err_q;
  assign o_commit_done = done_q;

endmodule
